// File: rtl/pingpong_write_ctrl_pkg.sv
// Shared types and width defaults for the ping-pong write path.
// These defaults are shared by the write controller, the demux and the buffer RAMs.
package pp_buf_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        STALL = 2'd2
    } state_t;

    typedef logic bank_t;

    function automatic bank_t other_bank(input bank_t b);
        return ~b;
    endfunction

endpackage

// File: rtl/pingpong_write_ctrl_if.sv
// Producer stream plus demux write bundle of the ping-pong write controller.
// The master modport is the controller side, and the slave modport is the producer/demux side.
interface pingpong_write_ctrl_if
    import pp_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              we;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              select;

    modport master (
        input  in_valid, in_data,
        output in_ready, we, data, addr, select
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, we, data, addr, select
    );
endinterface

// File: rtl/pingpong_write_ctrl_bank_tracker.sv
// Tracks which ping-pong bank holds a complete frame that has not yet been released.
// When a set and a release target the same bank, the set wins so that a completed frame is never lost.
module pp_bank_tracker
    import pp_buf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en,
    input  bank_t      set_bank,
    input  logic [1:0] rel,
    output logic [1:0] bank_full
);
    logic [1:0] full_reg;
    logic [1:0] full_next;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign full_next[gi] = (set_en && (set_bank == bank_t'(gi))) ? 1'b1 :
                                   rel[gi]                               ? 1'b0 :
                                                                           full_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= 2'b00;
        end else begin
            full_reg <= full_next;
        end
    end

    assign bank_full = full_reg;
endmodule

// File: rtl/pingpong_write_ctrl.sv
// Ping-pong write sequencer: fills one bank with DEPTH words, then flips to the other bank.
// It stalls the producer while the target bank is still unreleased. `PP_FRAME_CNT_EN adds the frame_cnt output.
module pingpong_write_ctrl
    import pp_buf_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] rel,
    pingpong_write_ctrl_if.master bus,
    output logic [1:0] bank_full,
    output logic       frame_done,
    output logic       busy
`ifdef PP_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    state_t            state_reg, state_next;
    bank_t             cur_bank_reg;
    logic [ADDR_W-1:0] word_cnt_reg;
    logic              we_reg;
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              select_reg;
    logic              frame_done_reg;
    logic              in_ready_int;
    logic              accept;
    logic              frame_end;

    assign in_ready_int = (state_reg == WRITE) && !bank_full[cur_bank_reg];
    assign accept       = bus.in_valid && in_ready_int;
    assign frame_end    = accept && (word_cnt_reg == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = WRITE;
            // Stall only if the bank we are about to flip into is still held by the reader
            WRITE:   if (frame_end && bank_full[other_bank(cur_bank_reg)]) state_next = STALL;
            STALL:   if (!bank_full[cur_bank_reg]) state_next = WRITE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_bank_reg   <= 1'b0;
            word_cnt_reg   <= '0;
            we_reg         <= 1'b0;
            data_reg       <= '0;
            addr_reg       <= '0;
            select_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            we_reg         <= accept;
            frame_done_reg <= frame_end;
            if (accept) begin
                data_reg   <= bus.in_data;
                addr_reg   <= BASE_ADDR + word_cnt_reg;
                select_reg <= cur_bank_reg;
                if (frame_end) begin
                    word_cnt_reg <= '0;
                    cur_bank_reg <= other_bank(cur_bank_reg);
                end else begin
                    word_cnt_reg <= word_cnt_reg + 1'b1;
                end
            end
        end
    end

    pp_bank_tracker u_bank_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (frame_end),
        .set_bank  (cur_bank_reg),
        .rel       (rel),
        .bank_full (bank_full)
    );

`ifdef PP_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= 16'd0;
        end else if (frame_end) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`endif

    assign bus.in_ready = in_ready_int;
    assign bus.we       = we_reg;
    assign bus.data     = data_reg;
    assign bus.addr     = addr_reg;
    assign bus.select   = select_reg;
    assign frame_done   = frame_done_reg;
    assign busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_pingpong_write_ctrl.sv
// Randomized self-checking bench for pingpong_write_ctrl, compared against a frame-level reference model.
// A second instance, with BASE_ADDR = 16'hFFFE, exercises address wrap-around.
module tb_pingpong_write_ctrl;
    import pp_buf_pkg::*;

    localparam int          DW    = 16;
    localparam int          AW    = 16;
    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'h0000;
    localparam logic [15:0] BASE2 = 16'hFFFE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] rel = 2'b00;
    logic [1:0] bank_full;
    logic       frame_done;
    logic       busy;
    logic       start2 = 1'b0;
    logic [1:0] rel2 = 2'b00;
    logic [1:0] bank_full2;
    logic       frame_done2;
    logic       busy2;
`ifdef PP_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] frame_cnt2;
`endif

    pingpong_write_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    pingpong_write_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

    pingpong_write_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rel        (rel),
        .bus        (bus.master),
        .bank_full  (bank_full),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef PP_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    pingpong_write_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .rel        (rel2),
        .bus        (bus2.master),
        .bank_full  (bank_full2),
        .frame_done (frame_done2),
        .busy       (busy2)
`ifdef PP_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt2)
`endif
    );

    always #5 clk = ~clk;

    int passes = 0;
    int checks = 0;

    // Frame-level reference model
    logic        m_started;
    logic        m_wait;
    logic        m_bank;
    int          m_cnt;
    logic [1:0]  m_full;
    int          m_frames;
    logic        e_we, e_fd, e_sel;
    logic [15:0] e_data, e_addr;

    logic [38:0] obs, exp_v;

    function automatic logic m_ready();
        return m_started && !m_wait && !m_full[m_bank];
    endfunction

    task automatic model_reset();
        m_started = 1'b0; m_wait = 1'b0; m_bank = 1'b0; m_cnt = 0; m_full = 2'b00; m_frames = 0;
        e_we = 1'b0; e_fd = 1'b0; e_sel = 1'b0; e_data = 16'h0; e_addr = 16'h0;
    endtask

    // Drive one cycle of stimulus, advance the model, and return at the following negedge
    task automatic tick(input logic v, input logic [15:0] d, input logic [1:0] r, input logic st);
        logic       acc, fd;
        logic [1:0] old_full;
        bus.in_valid = v; bus.in_data = d; rel = r; start = st;
        acc = v && m_ready();
        fd = acc && (m_cnt == DEPTH - 1);
        old_full = m_full;
        e_we = acc; e_fd = fd;
        if (acc) begin
            e_data = d; e_addr = BASE + 16'(m_cnt); e_sel = m_bank;
        end
        if (m_wait && !old_full[m_bank]) m_wait = 1'b0;
        m_full = m_full & ~r;
        if (fd) begin
            m_full[m_bank] = 1'b1;
            if (old_full[!m_bank]) m_wait = 1'b1;
            m_bank = !m_bank;
            m_cnt = 0;
            m_frames++;
        end else if (acc) begin
            m_cnt++;
        end
        if (st && !m_started) m_started = 1'b1;
        @(posedge clk);
        #1;
        rel = 2'b00; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 16'($urandom);
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        bus.in_valid = 1'b0; bus.in_data = 16'h0; bus2.in_valid = 1'b0; bus2.in_data = 16'h0;
        @(negedge clk);
        obs   = {bus.we, bus.select, frame_done, bank_full, bus.in_ready, busy, bus.addr, bus.data};
        exp_v = '0;
        checks++;
        if (obs !== exp_v) $display("FAIL reset_state got=%h want=%h", obs, exp_v);
        else passes++;
`ifdef PP_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt got=%h want=0", frame_cnt);
        else passes++;
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_base_wrap();
        logic [15:0] dq;
        logic [33:0] o2, e2;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        bus2.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dq = 16'($urandom);
            bus2.in_data = dq;
            @(negedge clk);
            o2 = {bus2.we, frame_done2, bus2.addr, bus2.data};
            e2 = {1'b1, (i == 3), BASE2 + 16'(i), dq};
            checks++;
            if (o2 !== e2) $display("FAIL base_wrap[%0d] got=%h want=%h", i, o2, e2);
            else passes++;
        end
        bus2.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_frame();
        tick(1'b0, 16'($urandom), 2'b00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick(1'b1, 16'($urandom), 2'b00, 1'b0);
            obs   = {bus.we, bus.select, frame_done, bank_full, bus.in_ready, busy, bus.addr, bus.data};
            exp_v = {e_we, e_sel, e_fd, m_full, m_ready(), m_started, e_addr, e_data};
            checks++;
            if (obs !== exp_v) $display("FAIL first_frame[%0d] got=%h want=%h", i, obs, exp_v);
            else passes++;
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 28; i++) begin
            tick(1'b1, 16'($urandom), (i == 23) ? 2'b01 : 2'b00, 1'b0);
            obs   = {bus.we, bus.select, frame_done, bank_full, bus.in_ready, busy, bus.addr, bus.data};
            exp_v = {e_we, e_sel, e_fd, m_full, m_ready(), m_started, e_addr, e_data};
            checks++;
            if (obs !== exp_v) $display("FAIL stall[%0d] got=%h want=%h", i, obs, exp_v);
            else passes++;
        end
`ifdef PP_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'(m_frames)) $display("FAIL stall_frame_cnt got=%0d want=%0d", frame_cnt, m_frames);
        else passes++;
`endif
    endtask

    task automatic test_rel_collision();
        logic [1:0] r;
        logic       hit;
        hit = 1'b0;
        for (int i = 0; i < 14; i++) begin
            r = 2'b00;
            if (i == 3) r = 2'b10;
            if (m_bank && (m_cnt == DEPTH - 1) && m_ready()) begin
                r = 2'b10;
                hit = 1'b1;
            end
            if (i == 12) r = 2'b11;
            tick(i != 12, 16'($urandom), r, 1'b0);
            obs   = {bus.we, bus.select, frame_done, bank_full, bus.in_ready, busy, bus.addr, bus.data};
            exp_v = {e_we, e_sel, e_fd, m_full, m_ready(), m_started, e_addr, e_data};
            checks++;
            if (obs !== exp_v) $display("FAIL rel_collision[%0d] got=%h want=%h", i, obs, exp_v);
            else passes++;
        end
        checks++;
        if (!hit) $display("FAIL rel_collision_reached got=0 want=1");
        else passes++;
    endtask

    task automatic test_backpressure();
        logic       v;
        logic [1:0] r;
        for (int i = 0; i < 80; i++) begin
            v = (i < 4) ? ((i % 2) == 0) : 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            tick(v, 16'($urandom), r, 1'b0);
            obs   = {bus.we, bus.select, frame_done, bank_full, bus.in_ready, busy, bus.addr, bus.data};
            exp_v = {e_we, e_sel, e_fd, m_full, m_ready(), m_started, e_addr, e_data};
            checks++;
            if (obs !== exp_v) $display("FAIL backpressure[%0d] got=%h want=%h", i, obs, exp_v);
            else passes++;
        end
    endtask

    task automatic test_reset_midframe();
        tick(1'b0, 16'h0, 2'b11, 1'b0);
        tick(1'b0, 16'h0, 2'b11, 1'b0);
        for (int i = 0; i < 20 && m_cnt != 2; i++) begin
            tick(1'b1, 16'($urandom), 2'b00, 1'b0);
            obs   = {bus.we, bus.select, frame_done, bank_full, bus.in_ready, busy, bus.addr, bus.data};
            exp_v = {e_we, e_sel, e_fd, m_full, m_ready(), m_started, e_addr, e_data};
            checks++;
            if (obs !== exp_v) $display("FAIL midframe_fill[%0d] got=%h want=%h", i, obs, exp_v);
            else passes++;
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        obs = {bus.we, bus.select, frame_done, bank_full, bus.in_ready, busy, bus.addr, bus.data};
        checks++;
        if (obs !== 39'h0) $display("FAIL async_reset got=%h want=0", obs);
        else passes++;
`ifdef PP_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd0) $display("FAIL async_reset_frame_cnt got=%h want=0", frame_cnt);
        else passes++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(i != 1, 16'($urandom), 2'b00, i == 1);
            obs   = {bus.we, bus.select, frame_done, bank_full, bus.in_ready, busy, bus.addr, bus.data};
            exp_v = {e_we, e_sel, e_fd, m_full, m_ready(), m_started, e_addr, e_data};
            checks++;
            if (obs !== exp_v) $display("FAIL restart[%0d] got=%h want=%h", i, obs, exp_v);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_base_wrap();
        test_first_frame();
        test_stall();
        test_rel_collision();
        test_backpressure();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
